logic16_checker: RTL and testbench

LOGIC16_CHECKER -- requirements
Module: logic16_checker

---
 rtl/logic16_pkg.sv | 21 ++
 rtl/logic16_checker_if.sv | 38 +++
 rtl/logic16_ref.sv | 25 ++
 rtl/logic16_checker.sv | 112 +++++++++++
 tb/tb_logic16_checker.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/logic16_pkg.sv
// Shared encodings for the 16-bit logic checker: reference-op codes and FSM states.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package logic16_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W = 16;

endpackage

// File: rtl/logic16_checker_if.sv
// Vector/result bus between a stimulus source and logic16_checker; LOGIC16_CHECK_CAPTURE_EN adds capture outputs.
// Latency: n/a (wires only).
// Backpressure: vec_valid/vec_ready handshake, transfer when both are high.
interface logic16_checker_if #(
    parameter int CNT_W = 8
) ();
    logic              start;
    logic [1:0]        op;
    logic              vec_valid;
    logic              vec_ready;
    logic [15:0]       a;
    logic [15:0]       b;
    logic [15:0]       y;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  vec_count;
`ifdef LOGIC16_CHECK_CAPTURE_EN
    logic [CNT_W-1:0]  fail_index;
    logic [15:0]       fail_mask;
`endif

    modport master (
        output start, op, vec_valid, a, b, y,
        input  vec_ready, done, pass, err_count, vec_count
`ifdef LOGIC16_CHECK_CAPTURE_EN
        , input fail_index, fail_mask
`endif
    );

    modport slave (
        input  start, op, vec_valid, a, b, y,
        output vec_ready, done, pass, err_count, vec_count
`ifdef LOGIC16_CHECK_CAPTURE_EN
        , output fail_index, fail_mask
`endif
    );
endinterface

// File: rtl/logic16_ref.sv
// Reference model of the device under check: res = f(op, a, b) over 16 bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module logic16_ref
    import logic16_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res
);

    // Select the reference boolean function for this vector.
    always_comb begin
        res = '0;
        case (op_t'(op))
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/logic16_checker.sv
// Checks NUM_VECTORS a/b/y vectors per run against a logic reference; optional capture via LOGIC16_CHECK_CAPTURE_EN.
// Latency: counters update one cycle after each transfer; DONE entered on the edge of the last transfer.
// Backpressure: vec_ready high only in RUN; vectors offered in IDLE/DONE are not consumed.
module logic16_checker
    import logic16_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    logic16_checker_if.slave    bus
);

    // The run counter is at least 8 bits wide so a run of up to 255 vectors
    // terminates even when CNT_W is narrower; vec_count shows its low bits.
    localparam int RUN_W = (CNT_W > 8) ? CNT_W : 8;

    state_t             state_q;
    state_t             state_d;
    logic [RUN_W-1:0]   run_cnt_q;
    logic [CNT_W-1:0]   err_q;
    logic [DATA_W-1:0]  expected;
    logic               ready;
    logic               done_s;
    logic               clear;
    logic               xfer;
    logic               mismatch;
    logic               last;

    logic16_ref u_ref (
        .op  (bus.op),
        .a   (bus.a),
        .b   (bus.b),
        .res (expected)
    );

    assign xfer     = bus.vec_valid && ready;
    assign mismatch = (bus.y != expected);
    assign last     = (run_cnt_q == RUN_W'(NUM_VECTORS - 1));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done_s  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (xfer && last) state_d = DONE;
            end
            DONE: begin
                done_s = 1'b1;
                if (bus.start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Vector/error counters: cleared on run start, stepped per transfer; errors saturate.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run_cnt_q <= '0;
            err_q     <= '0;
        end else if (xfer) begin
            run_cnt_q <= run_cnt_q + 1'b1;
            if (mismatch && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

`ifdef LOGIC16_CHECK_CAPTURE_EN
    logic [CNT_W-1:0]  fail_index_q;
    logic [DATA_W-1:0] fail_mask_q;

    // Capture index and differing bits of the first mismatch (error count still zero).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fail_index_q <= '0;
            fail_mask_q  <= '0;
        end else if (xfer && mismatch && (err_q == '0)) begin
            fail_index_q <= run_cnt_q[CNT_W-1:0];
            fail_mask_q  <= bus.y ^ expected;
        end
    end

    assign bus.fail_index = fail_index_q;
    assign bus.fail_mask  = fail_mask_q;
`endif

    assign bus.vec_ready = ready;
    assign bus.done      = done_s;
    assign bus.pass      = done_s && (err_q == '0);
    assign bus.err_count = err_q;
    assign bus.vec_count = run_cnt_q[CNT_W-1:0];

endmodule

// File: tb/tb_logic16_checker.sv
// Directed self-checking bench for logic16_checker (default build and a CNT_W=2 saturation instance).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next edge.
// Backpressure: exercises vec_valid stalls and vectors offered while vec_ready is low.
module tb_logic16_checker;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic16_checker_if #(.CNT_W(8)) bus ();
    logic16_checker_if #(.CNT_W(2)) bus2 ();

    logic16_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic16_checker #(.NUM_VECTORS(5), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic dn, input logic ps,
                              input logic [7:0] ec, input logic [7:0] vc);
        check({tag, ".vec_ready"}, {31'd0, bus.vec_ready}, {31'd0, rdy});
        check({tag, ".done"},      {31'd0, bus.done},      {31'd0, dn});
        check({tag, ".pass"},      {31'd0, bus.pass},      {31'd0, ps});
        check({tag, ".err_count"}, {24'd0, bus.err_count}, {24'd0, ec});
        check({tag, ".vec_count"}, {24'd0, bus.vec_count}, {24'd0, vc});
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] y);
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.y         = y;
        bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.vec_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.y = '0;
        bus2.start = 1'b0; bus2.op = 2'd0; bus2.vec_valid = 1'b0;
        bus2.a = '0; bus2.b = '0; bus2.y = '0;

        // Reset, with start asserted too: reset wins.
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_outs("reset", 0, 0, 0, 0, 0);
`ifdef LOGIC16_CHECK_CAPTURE_EN
        check("reset.fail_index", {24'd0, bus.fail_index}, 32'd0);
        check("reset.fail_mask",  {16'd0, bus.fail_mask},  32'd0);
`endif
        reset = 1'b0;
        tick();
        check_outs("idle", 0, 0, 0, 0, 0);

        // Passing AND run.
        pulse_start();
        check_outs("run1.start", 1, 0, 0, 0, 0);
        send(2'd0, 16'h5555, 16'h5555, 16'h5555);
        check_outs("run1.v0", 1, 0, 0, 0, 1);
        send(2'd0, 16'hCCCC, 16'h5555, 16'h4444);
        send(2'd0, 16'h85DD, 16'hFFFF, 16'h85DD);
        check_outs("run1.v2", 1, 0, 0, 0, 3);
        send(2'd0, 16'h0515, 16'h0000, 16'h0000);
        check_outs("run1.end", 0, 1, 1, 0, 4);
        // Vector offered while not ready must not be consumed.
        send(2'd0, 16'hFFFF, 16'hFFFF, 16'h0000);
        check_outs("run1.hold", 0, 1, 1, 0, 4);

        // Restart from DONE; failing second vector, stall and start pulse mid-run.
        pulse_start();
        check_outs("run2.restart", 1, 0, 0, 0, 0);
        send(2'd0, 16'h5555, 16'h5555, 16'h5555);
        send(2'd0, 16'hCCCC, 16'h5555, 16'h4445);
        check_outs("run2.v1", 1, 0, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("run2.stall", 1, 0, 0, 1, 2);
        end
        pulse_start();
        check_outs("run2.start_ignored", 1, 0, 0, 1, 2);
        send(2'd0, 16'h85DD, 16'hFFFF, 16'h85DD);
        send(2'd0, 16'h0515, 16'h0000, 16'h0000);
        check_outs("run2.end", 0, 1, 0, 1, 4);
`ifdef LOGIC16_CHECK_CAPTURE_EN
        check("run2.fail_index", {24'd0, bus.fail_index}, 32'd1);
        check("run2.fail_mask",  {16'd0, bus.fail_mask},  32'h0001);
`endif
        tick();
        check_outs("run2.hold", 0, 1, 0, 1, 4);

        // Reset mid-run abandons the run.
        pulse_start();
        send(2'd1, 16'h00F0, 16'h0F00, 16'h0000);
        send(2'd1, 16'h00F0, 16'h0F00, 16'h0FF0);
        check_outs("run3.two", 1, 0, 0, 1, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("run3.reset", 0, 0, 0, 0, 0);
`ifdef LOGIC16_CHECK_CAPTURE_EN
        check("run3.fail_index", {24'd0, bus.fail_index}, 32'd0);
        check("run3.fail_mask",  {16'd0, bus.fail_mask},  32'h0);
`endif

        // Full mixed-op passing run after reset, including NAND FFFF/00F0.
        pulse_start();
        send(2'd1, 16'h00F0, 16'h0F00, 16'h0FF0);
        send(2'd2, 16'hFFFF, 16'h1234, 16'hEDCB);
        send(2'd3, 16'hFFFF, 16'h00F0, 16'hFF0F);
        check_outs("run4.nand", 1, 0, 0, 0, 3);
        send(2'd0, 16'h1234, 16'h00FF, 16'h0034);
        check_outs("run4.end", 0, 1, 1, 0, 4);

        // Narrow-counter instance: five wrong vectors, error count saturates at 3.
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("sat.ready", {31'd0, bus2.vec_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus2.op = 2'd0; bus2.a = 16'hFFFF; bus2.b = 16'hFFFF; bus2.y = 16'h0000;
            bus2.vec_valid = 1'b1;
            tick();
            bus2.vec_valid = 1'b0;
            check("sat.err_count", {30'd0, bus2.err_count}, (i < 3) ? i + 1 : 3);
        end
        check("sat.done",  {31'd0, bus2.done},      32'd1);
        check("sat.pass",  {31'd0, bus2.pass},      32'd0);
        check("sat.ready_end", {31'd0, bus2.vec_ready}, 32'd0);
        check("sat.vec_count", {30'd0, bus2.vec_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
